// File: rtl/cfs_apb_pkg.sv
// Shared types and helpers for the CFS APB arbitrated master.
// Width macros may be overridden on the command line before this file is read.
`ifndef CFS_APB_MAX_ADDR_WIDTH
`define CFS_APB_MAX_ADDR_WIDTH 32
`endif

`ifndef CFS_APB_MAX_DATA_WIDTH
`define CFS_APB_MAX_DATA_WIDTH 32
`endif

package cfs_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } cfs_apb_arb_state_t;

  // Position reached when stepping 'offset' places from 'base' around a ring of 'n'.
  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

  function automatic int wrap_inc(input int idx, input int n);
    return rr_index(idx, 1, n);
  endfunction

endpackage

// File: rtl/cfs_apb_rr_arbiter.sv
// Combinational round-robin pick: first set bit of req_mask at or after ptr,
// returned both one-hot and as a binary index.
module cfs_apb_rr_arbiter
  import cfs_apb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_mask,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'(rr_index(int'(ptr), k, NUM_REQ));
      if (!grant_valid && req_mask[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cfs_apb_arb_master.sv
// Round-robin arbitrated APB master: one requester at a time is carried through
// SETUP/ACCESS, with a wait-state timeout so a stuck slave cannot hold the bus.
module cfs_apb_arb_master
  import cfs_apb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = `CFS_APB_MAX_ADDR_WIDTH,
  parameter int DATA_WIDTH     = `CFS_APB_MAX_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          pclk,
  input  logic                          preset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_slverr,
  output logic                          rsp_timeout,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic                          pwrite,
  output logic                          psel,
  output logic                          penable,
  output logic [DATA_WIDTH-1:0]         pwdata,
  input  logic                          pready,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pslverr
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  cfs_apb_arb_state_t state_q, state_d;

  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   gnt_idx_q;
  logic [NUM_REQ-1:0] gnt_oh_q;
  logic [CNT_W-1:0]   wait_cnt_q;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               xfer_done;
  logic               timeout_hit;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  logic                  psel_d;
  logic                  penable_d;
  logic [NUM_REQ-1:0]    done_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  slverr_d;
  logic                  timeout_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // A requester whose done pulse is on the bus this cycle is not re-served at once.
  assign eligible = req & ~done;

  cfs_apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_mask    (eligible),
    .ptr         (ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign xfer_done   = (state_q == ST_ACCESS) && pready;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == ST_ACCESS) && !pready &&
                       (wait_cnt_q == CNT_LAST);

  // NOTE: clocked state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (grant_valid) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (xfer_done || timeout_hit) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; the completion response is a single-cycle pulse.
  always_comb begin
    psel_d    = (state_d != ST_IDLE);
    penable_d = (state_d == ST_ACCESS);
    done_d    = '0;
    rdata_d   = '0;
    slverr_d  = 1'b0;
    timeout_d = 1'b0;
    if (xfer_done) begin
      done_d   = gnt_oh_q;
      rdata_d  = pwrite ? '0 : prdata;
      slverr_d = pslverr;
    end else if (timeout_hit) begin
      done_d    = gnt_oh_q;
      slverr_d  = 1'b1;
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      done        <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
      gnt_oh_q    <= '0;
      gnt_idx_q   <= '0;
      ptr_q       <= '0;
    end else begin
      psel        <= psel_d;
      penable     <= penable_d;
      done        <= done_d;
      rsp_rdata   <= rdata_d;
      rsp_slverr  <= slverr_d;
      rsp_timeout <= timeout_d;
      if (state_q == ST_IDLE && grant_valid) begin
        paddr     <= addr_arr[grant_idx];
        pwdata    <= wdata_arr[grant_idx];
        pwrite    <= req_write[grant_idx];
        gnt_oh_q  <= grant;
        gnt_idx_q <= grant_idx;
      end
      if (xfer_done || timeout_hit) begin
        ptr_q <= IDX_W'(wrap_inc(int'(gnt_idx_q), NUM_REQ));
      end
    end
  end

  // Wait-state counter: cleared in SETUP so every ACCESS phase starts from zero.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_SETUP) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_ACCESS && !pready && wait_cnt_q != CNT_MAX) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cfs_apb_arb_master.sv
// Directed bench for cfs_apb_arb_master: a vector table of single transfers
// plus hand sequences for arbitration order and reset during a transfer.
module tb_cfs_apb_arb_master;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            pclk = 1'b0;
  logic            preset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    done;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_slverr;
  logic            rsp_timeout;
  logic [AW-1:0]   paddr;
  logic            pwrite;
  logic            psel;
  logic            penable;
  logic [DW-1:0]   pwdata;
  logic            pready = 1'b0;
  logic [DW-1:0]   prdata = '0;
  logic            pslverr = 1'b0;

  cfs_apb_arb_master #(
    .NUM_REQ        (N),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .pclk        (pclk),
    .preset_n    (preset_n),
    .req         (req),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .done        (done),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .paddr       (paddr),
    .pwrite      (pwrite),
    .psel        (psel),
    .penable     (penable),
    .pwdata      (pwdata),
    .pready      (pready),
    .prdata      (prdata),
    .pslverr     (pslverr)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int psel_cycles = 0;
  always @(negedge pclk) if (psel) psel_cycles = psel_cycles + 1;

  // Slave model: inserts slv_wait wait states, then answers with slv_rdata/slv_err.
  int          slv_wait = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;
  int          wcnt = 0;

  always @(negedge pclk) begin
    if (psel && penable) begin
      if (wcnt < slv_wait) begin
        pready  = 1'b0;
        prdata  = ~slv_rdata;
        pslverr = 1'b0;
        wcnt    = wcnt + 1;
      end else begin
        pready  = 1'b1;
        prdata  = slv_rdata;
        pslverr = slv_err;
      end
    end else begin
      pready  = 1'b0;
      prdata  = '0;
      pslverr = 1'b0;
      wcnt    = 0;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int budget, output bit seen, output int at);
    seen = 1'b0;
    at   = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge pclk);
      if (done != '0) begin
        seen = 1'b1;
        at   = cyc;
        break;
      end
    end
  endtask

  task automatic set_req(input int idx, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
    req_write[idx]          = wr;
    req_addr[idx*AW +: AW]  = addr;
    req_wdata[idx*DW +: DW] = wdata;
  endtask

  typedef struct {
    int          idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_n;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int at;
    int t0;
    int p0;

    // idx wr addr wdata wait rdata err | exp_rdata exp_err exp_to latency
    vecs[0] = '{0, 1'b0, 32'h0000_0010, 32'h0000_0000, 3,    32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 6};
    vecs[1] = '{1, 1'b1, 32'h0000_0024, 32'h1234_5678, 0,    32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 3};
    vecs[2] = '{2, 1'b0, 32'h0000_0038, 32'h0F0F_0F0F, 0,    32'hA5A5_0001, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0, 3};
    vecs[3] = '{3, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1,    32'h7777_7777, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 4};
    vecs[4] = '{1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1000, 32'h0000_1111, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 10};
    vecs[5] = '{2, 1'b0, 32'h0000_0008, 32'h0000_0000, 7,    32'h8000_0008, 1'b0, 32'h8000_0008, 1'b0, 1'b0, 10};
    vecs[6] = '{0, 1'b0, 32'h0000_00A0, 32'h0000_0000, 2,    32'h0000_0055, 1'b1, 32'h0000_0055, 1'b1, 1'b0, 5};

    preset_n = 1'b0;
    repeat (3) @(negedge pclk);
    preset_n = 1'b1;

    check("rst_psel",    32'(psel),        32'd0);
    check("rst_penable", 32'(penable),     32'd0);
    check("rst_pwrite",  32'(pwrite),      32'd0);
    check("rst_paddr",   paddr,            32'd0);
    check("rst_pwdata",  pwdata,           32'd0);
    check("rst_done",    32'(done),        32'd0);
    check("rst_rdata",   rsp_rdata,        32'd0);
    check("rst_slverr",  32'(rsp_slverr),  32'd0);
    check("rst_timeout", 32'(rsp_timeout), 32'd0);

    // Two simultaneous requests right after reset: 0 then 1, each 2 psel cycles.
    @(negedge pclk);
    slv_wait  = 0;
    slv_rdata = 32'h0000_0B0B;
    slv_err   = 1'b0;
    set_req(0, 1'b0, 32'h100, 32'h0);
    set_req(1, 1'b0, 32'h200, 32'h0);
    req = 4'b0011;
    t0  = cyc;
    p0  = psel_cycles;
    for (int n = 0; n < 2; n++) begin
      wait_done(12, seen, at);
      check("pair_seen",  32'(seen), 32'd1);
      check("pair_grant", 32'(done), 32'd1 << n);
      check("pair_lat",   32'(at - t0), 32'(3 * (n + 1)));
      check("pair_rdata", rsp_rdata, 32'h0000_0B0B);
      req[n] = 1'b0;
    end
    check("pair_psel_cycles", 32'(psel_cycles - p0), 32'd4);

    // Reset during ACCESS with a stuck slave: bus drops at once, no done follows.
    @(negedge pclk);
    slv_wait = 1000;
    set_req(3, 1'b1, 32'h300, 32'h33);
    req = 4'b1000;
    repeat (2) @(negedge pclk);
    check("midrst_in_access", 32'(psel && penable), 32'd1);
    #2 preset_n = 1'b0;
    #1;
    check("midrst_psel",    32'(psel),    32'd0);
    check("midrst_penable", 32'(penable), 32'd0);
    req = '0;
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    wait_done(12, seen, at);
    check("midrst_no_done", 32'(seen), 32'd0);

    // All four held for eight transfers: strict rotation from requester 0.
    slv_wait = 0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h40 + 32'(i * 4), 32'h0);
    req = 4'b1111;
    t0  = cyc;
    for (int n = 0; n < 8; n++) begin
      wait_done(12, seen, at);
      check("rr_seen",  32'(seen), 32'd1);
      check("rr_grant", 32'(done), 32'd1 << (n % N));
      check("rr_lat",   32'(at - t0), 32'(3 * (n + 1)));
    end
    req = '0;

    // Single-transfer vector table.
    for (int v = 0; v < 7; v++) begin
      @(negedge pclk);
      slv_wait  = vecs[v].wait_n;
      slv_rdata = vecs[v].rdata;
      slv_err   = vecs[v].err;
      set_req(vecs[v].idx, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      req = 4'(1 << vecs[v].idx);
      t0  = cyc;
      @(negedge pclk);
      check("vec_setup_psel",    32'(psel),    32'd1);
      check("vec_setup_penable", 32'(penable), 32'd0);
      check("vec_paddr",         paddr,        vecs[v].addr);
      check("vec_pwrite",        32'(pwrite),  32'(vecs[v].wr));
      check("vec_pwdata",        pwdata,       vecs[v].wdata);
      @(negedge pclk);
      check("vec_access", 32'({psel, penable}), 32'd3);
      wait_done(20, seen, at);
      check("vec_seen",    32'(seen),        32'd1);
      check("vec_done",    32'(done),        32'd1 << vecs[v].idx);
      check("vec_lat",     32'(at - t0),     32'(vecs[v].exp_lat));
      check("vec_rdata",   rsp_rdata,        vecs[v].exp_rdata);
      check("vec_slverr",  32'(rsp_slverr),  32'(vecs[v].exp_err));
      check("vec_timeout", 32'(rsp_timeout), 32'(vecs[v].exp_to));
      check("vec_psel_low", 32'(psel),       32'd0);
      req = '0;
    end

    @(negedge pclk);
    check("end_done_clear", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
